// File: rtl/rll_pkg.sv
// Shared types and helpers for the sequential key-locked datapath stage.
package rll_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    ARMED   = 2'd2,
    ERROR   = 2'd3
  } key_state_e;

  localparam logic [15:0] KEY_POLARITY_DEFAULT = 16'h0000;

  function automatic int beats(input int key_width, input int shift_w);
    return key_width / shift_w;
  endfunction

endpackage

// File: rtl/rll_key_lock_stage_if.sv
// Key-load channel plus locked data channel of the key-lock stage.
interface rll_key_lock_stage_if #(
  parameter int SHIFT_W    = 1,
  parameter int DATA_WIDTH = 32
);
  logic                  key_valid;
  logic                  key_ready;
  logic [SHIFT_W-1:0]    key_data;
  logic                  key_last;
  logic                  key_clear;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_in_valid;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_valid;
  logic                  key_loaded;
  logic                  key_err;

  modport master (
    output key_valid, key_data, key_last, key_clear, data_in, data_in_valid,
    input  key_ready, data_out, data_out_valid, key_loaded, key_err
  );

  modport slave (
    input  key_valid, key_data, key_last, key_clear, data_in, data_in_valid,
    output key_ready, data_out, data_out_valid, key_loaded, key_err
  );
endinterface

// File: rtl/rll_key_loader.sv
// Serial key loader: LSB-first shadow shift register, beat counter and
// atomic commit into the active key.
module rll_key_loader
  import rll_pkg::*;
#(
  parameter int KEY_WIDTH = 16,
  parameter int SHIFT_W   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_valid,
  output logic                 key_ready,
  input  logic [SHIFT_W-1:0]   key_data,
  input  logic                 key_last,
  input  logic                 key_clear,
  output logic [KEY_WIDTH-1:0] active_key,
  output logic                 key_loaded,
  output logic                 key_err
);

  localparam int BEATS = beats(KEY_WIDTH, SHIFT_W);
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  key_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [KEY_WIDTH-1:0] shadow_q, shadow_d;
  logic [KEY_WIDTH-1:0] active_q, active_d;
  logic                 loaded_q, loaded_d;
  logic                 err_q, err_d;
  logic                 beat;
  logic [KEY_WIDTH-1:0] shifted;

  // New beat enters at the top so the first beat ends up in the LSBs.
  function automatic logic [KEY_WIDTH-1:0] shift_in(
    input logic [KEY_WIDTH-1:0] sh,
    input logic [SHIFT_W-1:0]   b
  );
    logic [KEY_WIDTH-1:0] wide;
    wide = KEY_WIDTH'(b);
    return (sh >> SHIFT_W) | (wide << (KEY_WIDTH - SHIFT_W));
  endfunction

  assign key_ready  = ~rst & ((state_q == IDLE) | (state_q == LOADING));
  assign beat       = key_valid & key_ready & ~key_clear;
  assign shifted    = shift_in(shadow_q, key_data);
  assign active_key = active_q;
  assign key_loaded = loaded_q;
  assign key_err    = err_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    loaded_d = loaded_q;
    err_d    = err_q;
    if (key_clear) begin
      state_d  = IDLE;
      cnt_d    = '0;
      shadow_d = '0;
      active_d = '0;
      loaded_d = 1'b0;
      err_d    = 1'b0;
    end else if (beat) begin
      shadow_d = shifted;
      cnt_d    = cnt_q + CNT_W'(1);
      state_d  = LOADING;
      if (cnt_q == LAST_CNT) begin
        if (key_last) begin
          active_d = shifted;
          loaded_d = 1'b1;
          cnt_d    = '0;
          state_d  = ARMED;
        end else begin
          err_d   = 1'b1;
          state_d = ERROR;
        end
      end else if (key_last) begin
        err_d   = 1'b1;
        state_d = ERROR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: rtl/rll_key_lock_stage.sv
// Registered XOR/XNOR key-gate stage driven by a serially loaded key.
module rll_key_lock_stage
  import rll_pkg::*;
#(
  parameter int                   KEY_WIDTH    = 16,
  parameter int                   DATA_WIDTH   = 32,
  parameter int                   SHIFT_W      = 1,
  parameter logic [KEY_WIDTH-1:0] KEY_POLARITY = KEY_WIDTH'(KEY_POLARITY_DEFAULT)
) (
  input logic                 clk,
  input logic                 rst,
  rll_key_lock_stage_if.slave bus
);

  logic [KEY_WIDTH-1:0]  active_key;
  logic [DATA_WIDTH-1:0] gated;
  logic [DATA_WIDTH-1:0] data_p1;
  logic                  vld_p1;

  rll_key_loader #(
    .KEY_WIDTH (KEY_WIDTH),
    .SHIFT_W   (SHIFT_W)
  ) u_loader (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (bus.key_valid),
    .key_ready  (bus.key_ready),
    .key_data   (bus.key_data),
    .key_last   (bus.key_last),
    .key_clear  (bus.key_clear),
    .active_key (active_key),
    .key_loaded (bus.key_loaded),
    .key_err    (bus.key_err)
  );

  // Polarity 1 turns the gate into XNOR, so a zero key still scrambles it.
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_gate
    assign gated[i] = bus.data_in[i] ^ active_key[i % KEY_WIDTH] ^ KEY_POLARITY[i % KEY_WIDTH];
  end

  // Stage p1: output flops of the locked path.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      data_p1 <= gated;
      vld_p1  <= bus.data_in_valid;
    end
  end

  assign bus.data_out       = data_p1;
  assign bus.data_out_valid = vld_p1;

endmodule

// File: tb/tb_rll_key_lock_stage.sv
// Scoreboard bench: default-parameter stage with a reference model, plus a
// 4-bit-beat XNOR-polarity stage checked with directed vectors.
module tb_rll_key_lock_stage;

  localparam int          KW_A   = 16;
  localparam int          SW_A   = 1;
  localparam int          BEATS_A = KW_A / SW_A;
  localparam logic [15:0] POL_A  = 16'h0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rll_key_lock_stage_if #(.SHIFT_W(1), .DATA_WIDTH(32)) ifa ();
  rll_key_lock_stage_if #(.SHIFT_W(4), .DATA_WIDTH(32)) ifb ();

  rll_key_lock_stage #(
    .KEY_WIDTH(16), .DATA_WIDTH(32), .SHIFT_W(1), .KEY_POLARITY(16'h0000)
  ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

  rll_key_lock_stage #(
    .KEY_WIDTH(16), .DATA_WIDTH(32), .SHIFT_W(4), .KEY_POLARITY(16'hFFFF)
  ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q[$];
  int          m_beats[$];
  logic [15:0] m_key;
  logic        m_loaded;
  logic        m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each data wire is XORed with its key bit, inverted again where polarity is 1.
  function automatic logic [31:0] lock_a(input logic [31:0] d, input logic [15:0] k);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = d[i] ^ k[i % KW_A] ^ POL_A[i % KW_A];
    return r;
  endfunction

  function automatic logic [15:0] assemble_key();
    logic [15:0] k;
    k = '0;
    for (int i = 0; i < m_beats.size(); i++) k = k | (16'(m_beats[i]) << (i * SW_A));
    return k;
  endfunction

  // Scoreboard monitor: every valid output is matched against the oldest prediction.
  always @(negedge clk) begin
    if (ifa.data_out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL data_out_unexpected: got %h with no prediction queued at %0t", ifa.data_out, $time);
      end else begin
        check("data_out", ifa.data_out, exp_q.pop_front());
      end
    end
  end

  // One clock of dut_a with the inputs currently driven; model advances alongside.
  task automatic cycle_a();
    logic rdy_e;
    logic beat;
    logic was_rst;
    #1;
    rdy_e = !rst && !m_loaded && !m_err;
    check("key_ready", {31'b0, ifa.key_ready}, {31'b0, rdy_e});
    check("key_loaded", {31'b0, ifa.key_loaded}, {31'b0, m_loaded});
    check("key_err", {31'b0, ifa.key_err}, {31'b0, m_err});
    if (!rst && ifa.data_in_valid) exp_q.push_back(lock_a(ifa.data_in, m_key));
    beat    = ifa.key_valid && rdy_e && !ifa.key_clear;
    was_rst = rst;
    if (rst || ifa.key_clear) begin
      m_key = '0; m_loaded = 1'b0; m_err = 1'b0; m_beats.delete();
    end else if (beat) begin
      m_beats.push_back(int'(ifa.key_data));
      if (m_beats.size() == BEATS_A) begin
        if (ifa.key_last) begin
          m_key = assemble_key(); m_loaded = 1'b1; m_beats.delete();
        end else m_err = 1'b1;
      end else if (ifa.key_last) m_err = 1'b1;
    end
    @(posedge clk);
    #1;
    if (was_rst) begin
      check("rst_data_out", ifa.data_out, 32'h0);
      check("rst_data_out_valid", {31'b0, ifa.data_out_valid}, 32'h0);
    end
  endtask

  task automatic idle_a();
    ifa.key_valid = 0; ifa.key_last = 0; ifa.key_clear = 0; ifa.key_data = '0;
  endtask

  task automatic load_a(input logic [15:0] key, input int nbeats, input int last_at);
    for (int i = 0; i < nbeats; i++) begin
      ifa.key_valid     = 1'b1;
      ifa.key_data      = key[i];
      ifa.key_last      = (i + 1 == last_at);
      ifa.data_in       = $urandom;
      ifa.data_in_valid = $urandom_range(0, 1);
      cycle_a();
    end
    idle_a();
  endtask

  task automatic clear_a();
    ifa.key_clear = 1'b1;
    cycle_a();
    ifa.key_clear = 1'b0;
  endtask

  task automatic send_a(input logic [31:0] d);
    ifa.data_in = d; ifa.data_in_valid = 1'b1;
    cycle_a();
    ifa.data_in_valid = 1'b0;
  endtask

  task automatic tick_b();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_a();
    ifa.data_in = '0; ifa.data_in_valid = 0;
    ifb.key_valid = 0; ifb.key_last = 0; ifb.key_clear = 0; ifb.key_data = '0;
    ifb.data_in = '0; ifb.data_in_valid = 0;
    m_key = '0; m_loaded = 0; m_err = 0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    cycle_a();
    rst = 1'b0;
    check("reset_key_err", {31'b0, ifa.key_err}, 32'h0);
    cycle_a();

    // Correct key, default polarity: transparent
    load_a(16'h0000, 16, 16);
    check("loaded_after_last", {31'b0, ifa.key_loaded}, 32'h1);
    send_a(32'hDEAD_BEEF);
    check("correct_key_out", ifa.data_out, 32'hDEAD_BEEF);

    // Wrong key flips bits 0 and 16
    clear_a();
    load_a(16'h0001, 16, 16);
    send_a(32'h0000_0000);
    check("wrong_key_out", ifa.data_out, 32'h0001_0001);

    // Short load: error, further beats ignored, key stays zero
    clear_a();
    load_a(16'hA5A5, 5, 5);
    check("short_err", {31'b0, ifa.key_err}, 32'h1);
    check("short_ready", {31'b0, ifa.key_ready}, 32'h0);
    check("short_loaded", {31'b0, ifa.key_loaded}, 32'h0);
    load_a(16'hFFFF, 16, 16);
    send_a(32'h0000_0000);
    check("short_key_zero", ifa.data_out, 32'h0);

    // key_clear in ARMED beats a simultaneous key beat
    clear_a();
    load_a(16'h0001, 16, 16);
    ifa.key_valid = 1; ifa.key_last = 1; ifa.key_data = 1'b1; ifa.key_clear = 1;
    cycle_a();
    idle_a();
    #1;
    check("clear_ready", {31'b0, ifa.key_ready}, 32'h1);
    check("clear_loaded", {31'b0, ifa.key_loaded}, 32'h0);
    send_a(32'h0000_0000);
    check("clear_key_zero", ifa.data_out, 32'h0);

    // rst during beat 9, then a full reload
    load_a(16'h1234, 8, 0);
    ifa.key_valid = 1; ifa.key_data = 1'b1; rst = 1;
    cycle_a();
    rst = 0;
    idle_a();
    check("rst_mid_loaded", {31'b0, ifa.key_loaded}, 32'h0);
    check("rst_mid_err", {31'b0, ifa.key_err}, 32'h0);
    check("rst_mid_out", ifa.data_out, 32'h0);
    load_a(16'hBEEF, 16, 16);
    send_a(32'h0000_0000);
    check("reload_out", ifa.data_out, 32'hBEEF_BEEF);

    // Randomised traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst               = ($urandom_range(0, 99) == 0);
      ifa.key_clear     = ($urandom_range(0, 39) == 0);
      ifa.key_valid     = $urandom_range(0, 1);
      ifa.key_data      = $urandom_range(0, 1);
      ifa.key_last      = (m_beats.size() == BEATS_A - 1) ? ($urandom_range(0, 5) != 0)
                                                         : ($urandom_range(0, 24) == 0);
      ifa.data_in       = $urandom;
      ifa.data_in_valid = $urandom_range(0, 1);
      cycle_a();
    end
    rst = 0;
    idle_a();
    ifa.data_in_valid = 0;
    cycle_a();
    cycle_a();
    check("scoreboard_drained", exp_q.size(), 32'h0);

    // dut_b: 4-bit beats, all-XNOR polarity
    ifb.data_in = '0; ifb.data_in_valid = 1;
    tick_b();
    check("b_zero_key_out", ifb.data_out, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) begin
      ifb.key_valid = 1; ifb.key_data = 4'(i + 1); ifb.key_last = (i == 3);
      tick_b();
    end
    ifb.key_valid = 0; ifb.key_last = 0;
    check("b_loaded", {31'b0, ifb.key_loaded}, 32'h1);
    check("b_ready_armed", {31'b0, ifb.key_ready}, 32'h0);
    check("b_commit_cycle_old_key", ifb.data_out, 32'hFFFF_FFFF);
    tick_b();
    check("b_key_4321", ifb.data_out, 32'hBCDE_BCDE);
    ifb.key_clear = 1; ifb.key_valid = 1; ifb.key_data = 4'hF; ifb.key_last = 1;
    tick_b();
    ifb.key_clear = 0; ifb.key_valid = 0; ifb.key_last = 0;
    check("b_clear_ready", {31'b0, ifb.key_ready}, 32'h1);
    check("b_clear_loaded", {31'b0, ifb.key_loaded}, 32'h0);
    tick_b();
    check("b_clear_out", ifb.data_out, 32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
